computer: RTL and testbench

Top level of the 8-bit SAP-2 machine: CPU core (program counter, instruction register, operand latches, accumulator, control unit), a 4 KiB ROM at F000–FFFF and a 256-byte RAM at 0000–00FF. It boots from ROM at F000 and fetches variable-length instructions (1–3 bytes) through a multi-byte fetch FSM. It stops in a halt state on `HLT`. The block is the simulation and synthesis top; its only ports are clock and reset.

---
 rtl/computer_if.sv | 22 ++
 rtl/computer.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_computer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/computer_if.sv
// Memory bus between the SAP-2 core and its memories.
// master: addr/wdata/re/we out, rdata in; slave: the reverse.
interface computer_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          re;
    logic          we;

    modport master (
        output addr, wdata, re, we,
        input  rdata
    );

    modport slave (
        input  addr, wdata, re, we,
        output rdata
    );
endinterface

// File: rtl/computer.sv
// SAP-2 computer: 8-bit core, 4 KiB ROM at F000, RAM at 0000.
// Ports: clk, reset (sync, active-low). SIM_MEM_TASKS_EN adds mem tasks.

module program_counter #(
    parameter int                AW       = 16,
    parameter logic [AW-1:0]     RESET_PC = 16'hF000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    output logic [AW-1:0] counter_out
);
    logic [AW-1:0] cnt_d, cnt_q;

    // Natural wrap FFFF -> 0000.
    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (inc)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            cnt_q <= RESET_PC;
        else
            cnt_q <= cnt_d;
    end

    assign counter_out = cnt_q;
endmodule

module data_register #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] din,
    output logic [W-1:0] latched_data
);
    logic [W-1:0] data_d, data_q;

    always_comb begin
        data_d = data_q;
        if (load)
            data_d = din;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            data_q <= '0;
        else
            data_q <= data_d;
    end

    assign latched_data = data_q;
endmodule

module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ir,
    output logic [2:0] current_state,
    output logic       mem_read,
    output logic       mem_write,
    output logic       addr_sel,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       mar_load,
    output logic       ir_load,
    output logic       lo_load,
    output logic       hi_load,
    output logic       a_load_imm,
    output logic       a_load_mem,
    output logic       halt
);
    typedef enum logic [2:0] {
        S_INIT       = 3'd0,
        S_LATCH_ADDR = 3'd1,
        S_READ_BYTE  = 3'd2,
        S_LATCH_BYTE = 3'd3,
        S_CHK_MORE   = 3'd4,
        S_EXECUTE    = 3'd5,
        S_WAIT       = 3'd6,
        S_HALT       = 3'd7
    } state_t;

    localparam logic [7:0] OP_HLT = 8'h01;
    localparam logic [7:0] OP_LDI = 8'h10;
    localparam logic [7:0] OP_JMP = 8'h20;
    localparam logic [7:0] OP_STA = 8'h30;
    localparam logic [7:0] OP_LDA = 8'h31;

    state_t     state_d, state_q;
    logic [1:0] cnt_d, cnt_q;
    logic [1:0] len;

    // Instruction length in bytes; unknown opcodes are 1-byte NOPs.
    always_comb begin
        len = 2'd1;
        case (ir)
            OP_LDI:                 len = 2'd2;
            OP_JMP, OP_STA, OP_LDA: len = 2'd3;
            default:                len = 2'd1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        addr_sel   = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        mar_load   = 1'b0;
        ir_load    = 1'b0;
        lo_load    = 1'b0;
        hi_load    = 1'b0;
        a_load_imm = 1'b0;
        a_load_mem = 1'b0;
        case (state_q)
            S_INIT: begin
                cnt_d   = 2'd0;
                state_d = S_LATCH_ADDR;
            end
            S_LATCH_ADDR: begin
                mar_load = 1'b1;
                state_d  = S_READ_BYTE;
            end
            S_READ_BYTE: begin
                mem_read = 1'b1;
                pc_inc   = 1'b1;
                state_d  = S_LATCH_BYTE;
            end
            S_LATCH_BYTE: begin
                mem_read = 1'b1;
                ir_load  = (cnt_q == 2'd0);
                lo_load  = (cnt_q == 2'd1);
                hi_load  = (cnt_q == 2'd2);
                cnt_d    = cnt_q + 2'd1;
                state_d  = S_CHK_MORE;
            end
            S_CHK_MORE: begin
                if (cnt_q < len)
                    state_d = S_LATCH_ADDR;
                else
                    state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                cnt_d   = 2'd0;
                state_d = S_LATCH_ADDR;
                case (ir)
                    OP_HLT: state_d = S_HALT;
                    OP_LDI: a_load_imm = 1'b1;
                    OP_JMP: pc_load = 1'b1;
                    OP_STA: begin
                        addr_sel  = 1'b1;
                        mem_write = 1'b1;
                    end
                    OP_LDA: begin
                        addr_sel = 1'b1;
                        mem_read = 1'b1;
                        state_d  = S_WAIT;
                    end
                    default: ;
                endcase
            end
            S_WAIT: begin
                a_load_mem = 1'b1;
                cnt_d      = 2'd0;
                state_d    = S_LATCH_ADDR;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_INIT;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign current_state = state_q;
    assign halt = (state_q == S_HALT) |
                  ((state_q == S_EXECUTE) & (ir == OP_HLT));
endmodule

module cpu #(
    parameter int            AW       = 16,
    parameter int            DW       = 8,
    parameter logic [AW-1:0] RESET_PC = 16'hF000
) (
    input  logic       clk,
    input  logic       reset,
    computer_if.master bus,
    output logic       halt
);
    logic          mem_read, mem_write, addr_sel;
    logic          pc_inc, pc_load, mar_load;
    logic          ir_load, lo_load, hi_load;
    logic          a_load_imm, a_load_mem;
    logic [2:0]    state;
    logic [DW-1:0] ir, op_lo, op_hi, acc, acc_din;
    logic [AW-1:0] pc, op_addr;
    logic [AW-1:0] mar_d, mar_q;

    // Little-endian operand address.
    assign op_addr = {op_hi, op_lo};
    assign acc_din = a_load_mem ? bus.rdata : op_lo;

    control_unit u_control_unit (
        .clk           (clk),
        .reset         (reset),
        .ir            (ir),
        .current_state (state),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .addr_sel      (addr_sel),
        .pc_inc        (pc_inc),
        .pc_load       (pc_load),
        .mar_load      (mar_load),
        .ir_load       (ir_load),
        .lo_load       (lo_load),
        .hi_load       (hi_load),
        .a_load_imm    (a_load_imm),
        .a_load_mem    (a_load_mem),
        .halt          (halt)
    );

    program_counter #(.AW(AW), .RESET_PC(RESET_PC)) u_program_counter (
        .clk         (clk),
        .reset       (reset),
        .inc         (pc_inc),
        .load        (pc_load),
        .load_val    (op_addr),
        .counter_out (pc)
    );

    data_register #(.W(DW)) u_register_instr (
        .clk(clk), .reset(reset), .load(ir_load),
        .din(bus.rdata), .latched_data(ir)
    );

    data_register #(.W(DW)) u_register_lo (
        .clk(clk), .reset(reset), .load(lo_load),
        .din(bus.rdata), .latched_data(op_lo)
    );

    data_register #(.W(DW)) u_register_hi (
        .clk(clk), .reset(reset), .load(hi_load),
        .din(bus.rdata), .latched_data(op_hi)
    );

    data_register #(.W(DW)) u_register_a (
        .clk(clk), .reset(reset), .load(a_load_imm | a_load_mem),
        .din(acc_din), .latched_data(acc)
    );

    always_comb begin
        mar_d = mar_q;
        if (mar_load)
            mar_d = pc;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            mar_q <= RESET_PC;
        else
            mar_q <= mar_d;
    end

    // Only LDA/STA in EXECUTE drive the operand address.
    assign bus.addr  = addr_sel ? op_addr : mar_q;
    assign bus.re    = mem_read;
    assign bus.we    = mem_write;
    assign bus.wdata = acc;

    logic unused_state;
    assign unused_state = ^state;
endmodule

module mem_block #(
    parameter int AW        = 16,
    parameter int DW        = 8,
    parameter int DEPTH     = 256,
    parameter bit READ_ONLY = 1'b0
) (
    input  logic      clk,
    input  logic      reset,
    computer_if.slave bus
);
    localparam int IW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_d, rdata_q;
    logic [IW-1:0] idx;

    assign idx = bus.addr[IW-1:0];

    logic unused_addr;
    assign unused_addr = ^bus.addr[AW-1:IW];

    // Unselected reads return zero so the top can OR the memories.
    always_comb begin
        rdata_d = '0;
        if (bus.re)
            rdata_d = mem[idx];
    end

    always_ff @(posedge clk) begin
        if (!reset)
            rdata_q <= '0;
        else
            rdata_q <= rdata_d;
    end

    always_ff @(posedge clk) begin
        if (bus.we && !READ_ONLY)
            mem[idx] <= bus.wdata;
    end

    assign bus.rdata = rdata_q;

`ifdef SIM_MEM_TASKS_EN
    task automatic init_sim_rom();
        for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
    endtask

    task automatic init_sim_ram();
        for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
    endtask

    task automatic dump();
        for (int i = 0; i < DEPTH; i++)
            if (mem[i] != '0)
                $display("mem[%0h] = %02h", i, mem[i]);
    endtask
`else
`endif
endmodule

module computer #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] ROM_BASE   = 16'hF000,
    parameter int                    RAM_DEPTH  = 256
) (
    input logic clk,
    input logic reset
);
    localparam int ROM_DEPTH = 4096;
    localparam logic [ADDR_WIDTH-1:0] RAM_TOP =
        ADDR_WIDTH'(RAM_DEPTH);

    computer_if #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) cpu_bus ();
    computer_if #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) rom_bus ();
    computer_if #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) ram_bus ();

    logic cpu_halt;
    logic rom_sel, ram_sel;

    assign rom_sel = (cpu_bus.addr >= ROM_BASE) & ~cpu_halt;
    assign ram_sel = (cpu_bus.addr < RAM_TOP) & ~cpu_halt;

    assign rom_bus.addr  = cpu_bus.addr;
    assign rom_bus.wdata = cpu_bus.wdata;
    assign rom_bus.re    = cpu_bus.re & rom_sel;
    assign rom_bus.we    = cpu_bus.we & rom_sel;

    assign ram_bus.addr  = cpu_bus.addr;
    assign ram_bus.wdata = cpu_bus.wdata;
    assign ram_bus.re    = cpu_bus.re & ram_sel;
    assign ram_bus.we    = cpu_bus.we & ram_sel;

    // Unmapped addresses fall through as 00.
    assign cpu_bus.rdata = rom_bus.rdata | ram_bus.rdata;

    cpu #(
        .AW(ADDR_WIDTH), .DW(DATA_WIDTH), .RESET_PC(ROM_BASE)
    ) u_cpu (
        .clk   (clk),
        .reset (reset),
        .bus   (cpu_bus),
        .halt  (cpu_halt)
    );

    mem_block #(
        .AW(ADDR_WIDTH), .DW(DATA_WIDTH),
        .DEPTH(ROM_DEPTH), .READ_ONLY(1'b1)
    ) u_rom (
        .clk(clk), .reset(reset), .bus(rom_bus)
    );

    mem_block #(
        .AW(ADDR_WIDTH), .DW(DATA_WIDTH),
        .DEPTH(RAM_DEPTH), .READ_ONLY(1'b0)
    ) u_ram (
        .clk(clk), .reset(reset), .bus(ram_bus)
    );
endmodule

// File: tb/tb_computer.sv
// Bench for the SAP-2 computer top.
// Programs loaded into ROM; results scoreboarded at halt.
module tb_computer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int total = 0;
    int bad = 0;

    computer dut (
        .clk   (clk),
        .reset (reset)
    );

    always #5 clk = ~clk;

    logic [2:0]  st;
    logic [15:0] pc;
    logic [7:0]  ir, acc;
    logic        rd, hlt;
    assign st  = dut.u_cpu.u_control_unit.current_state;
    assign pc  = dut.u_cpu.u_program_counter.counter_out;
    assign ir  = dut.u_cpu.u_register_instr.latched_data;
    assign acc = dut.u_cpu.u_register_a.latched_data;
    assign rd  = dut.u_cpu.mem_read;
    assign hlt = dut.cpu_halt;

    typedef struct {
        string       name;
        logic [15:0] pc;
        logic [7:0]  a;
        bit          chk_ram;
        logic [7:0]  ram_idx;
        logic [7:0]  ram_val;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++)
            dut.u_rom.mem[i] = 8'h00;
        for (int i = 0; i < 256; i++)
            dut.u_ram.mem[i] = 8'h00;
    endtask

    task automatic rom(input logic [15:0] a, input logic [7:0] d);
        dut.u_rom.mem[a[11:0]] = d;
    endtask

    task automatic push(input string n, input logic [15:0] p,
                        input logic [7:0] a, input bit c,
                        input logic [7:0] ri, input logic [7:0] rv);
        exp_t e;
        e.name = n;
        e.pc = p;
        e.a = a;
        e.chk_ram = c;
        e.ram_idx = ri;
        e.ram_val = rv;
        exp_q.push_back(e);
    endtask

    task automatic apply_reset(input bit chk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        if (chk) begin
            check("rst_state", st, 3'd0);
            check("rst_pc", pc, 16'hF000);
            check("rst_ir", ir, 8'h00);
            check("rst_a", acc, 8'h00);
            check("rst_rd", rd, 1'b0);
            check("rst_halt", hlt, 1'b0);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_check(input int budget);
        exp_t e;
        int n = 0;
        while (st != 3'd7 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("sb_size", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.name, "_halted"}, st, 3'd7);
            check({e.name, "_halt"}, hlt, 1'b1);
            check({e.name, "_pc"}, pc, e.pc);
            check({e.name, "_a"}, acc, e.a);
            if (e.chk_ram)
                check({e.name, "_ram"},
                      dut.u_ram.mem[e.ram_idx], e.ram_val);
        end
    endtask

    initial begin
        // HLT at F000 with cycle-level timing checks.
        clear_mem();
        rom(16'hF000, 8'h01);
        apply_reset(1'b1);
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) begin
                check("e1_state", st, 3'd1);
                check("e1_rd", rd, 1'b0);
            end
            if (e == 2) begin
                check("e2_state", st, 3'd2);
                check("e2_rd", rd, 1'b1);
            end
            if (e == 3) begin
                check("e3_state", st, 3'd3);
                check("e3_rd", rd, 1'b1);
                check("e3_pc", pc, 16'hF001);
            end
            if (e == 4) begin
                check("e4_state", st, 3'd4);
                check("e4_ir", ir, 8'h01);
                check("e4_halt", hlt, 1'b0);
            end
            if (e == 5) begin
                check("e5_state", st, 3'd5);
                check("e5_halt", hlt, 1'b1);
            end
            if (e == 6)
                check("e6_state", st, 3'd7);
            if (e == 16) begin
                check("e16_state", st, 3'd7);
                check("e16_pc", pc, 16'hF001);
            end
        end
        push("hlt", 16'hF001, 8'h00, 1'b0, 8'h00, 8'h00);
        run_check(10);

        // LDI then HLT, then reset from HALT and rerun.
        clear_mem();
        rom(16'hF000, 8'h10);
        rom(16'hF001, 8'h5A);
        rom(16'hF002, 8'h01);
        push("ldi", 16'hF003, 8'h5A, 1'b0, 8'h00, 8'h00);
        apply_reset(1'b0);
        run_check(100);
        push("ldi_again", 16'hF003, 8'h5A, 1'b0, 8'h00, 8'h00);
        apply_reset(1'b1);
        run_check(100);

        // LDI 3C; STA 0010; LDA 0010; HLT.
        clear_mem();
        rom(16'hF000, 8'h10);
        rom(16'hF001, 8'h3C);
        rom(16'hF002, 8'h30);
        rom(16'hF003, 8'h10);
        rom(16'hF004, 8'h00);
        rom(16'hF005, 8'h31);
        rom(16'hF006, 8'h10);
        rom(16'hF007, 8'h00);
        rom(16'hF008, 8'h01);
        push("sta_lda", 16'hF009, 8'h3C, 1'b1, 8'h10, 8'h3C);
        apply_reset(1'b0);
        run_check(200);

        // LDA from a preloaded RAM byte.
        clear_mem();
        dut.u_ram.mem[8'h20] = 8'hA7;
        rom(16'hF000, 8'h31);
        rom(16'hF001, 8'h20);
        rom(16'hF002, 8'h00);
        rom(16'hF003, 8'h01);
        push("lda_ram", 16'hF004, 8'hA7, 1'b1, 8'h20, 8'hA7);
        apply_reset(1'b0);
        run_check(200);

        // JMP F100; HLT at F100.
        clear_mem();
        rom(16'hF000, 8'h20);
        rom(16'hF001, 8'h00);
        rom(16'hF002, 8'hF1);
        rom(16'hF100, 8'h01);
        push("jmp", 16'hF101, 8'h00, 1'b0, 8'h00, 8'h00);
        apply_reset(1'b0);
        run_check(200);

        // Undefined opcode FF behaves as NOP.
        clear_mem();
        rom(16'hF000, 8'hFF);
        rom(16'hF001, 8'h01);
        push("undef", 16'hF002, 8'h00, 1'b0, 8'h00, 8'h00);
        apply_reset(1'b0);
        run_check(200);

        // STA into ROM is ignored; LDA reads original byte.
        clear_mem();
        rom(16'hF000, 8'h10);
        rom(16'hF001, 8'h77);
        rom(16'hF002, 8'h30);
        rom(16'hF003, 8'h0A);
        rom(16'hF004, 8'hF0);
        rom(16'hF005, 8'h31);
        rom(16'hF006, 8'h0A);
        rom(16'hF007, 8'hF0);
        rom(16'hF008, 8'h01);
        rom(16'hF00A, 8'h55);
        push("rom_ro", 16'hF009, 8'h55, 1'b0, 8'h00, 8'h00);
        apply_reset(1'b0);
        run_check(200);
        check("rom_ro_mem", dut.u_rom.mem[10], 8'h55);

        // LDA from unmapped 1234 returns 00.
        clear_mem();
        rom(16'hF000, 8'h10);
        rom(16'hF001, 8'h77);
        rom(16'hF002, 8'h31);
        rom(16'hF003, 8'h34);
        rom(16'hF004, 8'h12);
        rom(16'hF005, 8'h01);
        push("unmapped_rd", 16'hF006, 8'h00, 1'b0, 8'h00, 8'h00);
        apply_reset(1'b0);
        run_check(200);

        // STA to unmapped 0100 must not alias RAM[00].
        clear_mem();
        dut.u_ram.mem[8'h00] = 8'h11;
        rom(16'hF000, 8'h10);
        rom(16'hF001, 8'h66);
        rom(16'hF002, 8'h30);
        rom(16'hF003, 8'h00);
        rom(16'hF004, 8'h01);
        rom(16'hF005, 8'h01);
        push("unmapped_wr", 16'hF006, 8'h66, 1'b1, 8'h00, 8'h11);
        apply_reset(1'b0);
        run_check(200);

        // JMP FFFF; NOP at FFFF; PC wraps to RAM[0]=HLT.
        clear_mem();
        rom(16'hF000, 8'h20);
        rom(16'hF001, 8'hFF);
        rom(16'hF002, 8'hFF);
        rom(16'hFFFF, 8'h00);
        dut.u_ram.mem[8'h00] = 8'h01;
        push("pc_wrap", 16'h0001, 8'h00, 1'b0, 8'h00, 8'h00);
        apply_reset(1'b0);
        run_check(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
